// File: rtl/timer_pkg.sv
// Shared state type and BCD constants for the microwave timer digit-entry slice.
package timer_pkg;

    localparam int BCD_W = 4;

    localparam logic [BCD_W-1:0] SEC_TENS_MAX = 4'd5;
    localparam logic [BCD_W-1:0] MIN_MAX      = 4'd9;
    localparam logic [BCD_W-1:0] BCD_MAX      = 4'd9;
    localparam int               SEC_WRAP     = 60;

    typedef enum logic [2:0] {
        IDLE,
        ENTRY,
        NORM,
        LOAD,
        RUN
    } state_t;

endpackage

// File: rtl/timer_normalize.sv
// Combinational M:SS normaliser for raw keypad digits.
// TIMER_ENTRY_NORM_EN selects seconds carry plus 9:59 clamp; otherwise pass-through with a seconds-tens range check.
module timer_normalize
    import timer_pkg::*;
(
    input  logic [BCD_W-1:0] raw_min,
    input  logic [BCD_W-1:0] raw_tens,
    input  logic [BCD_W-1:0] raw_ones,
    output logic [BCD_W-1:0] norm_min,
    output logic [BCD_W-1:0] norm_tens,
    output logic [BCD_W-1:0] norm_ones,
    output logic             clamped,
    output logic             invalid
);

`ifdef TIMER_ENTRY_NORM_EN
    localparam logic [BCD_W-1:0] WRAP_TENS = BCD_W'(SEC_WRAP / 10);
`endif

    always_comb begin
        norm_min  = raw_min;
        norm_tens = raw_tens;
        norm_ones = raw_ones;
        clamped   = 1'b0;
        invalid   = 1'b0;
`ifdef TIMER_ENTRY_NORM_EN
        // Ones digit is unaffected by subtracting 60, so only tens and minutes move.
        if (raw_tens >= WRAP_TENS) begin
            if (raw_min >= MIN_MAX) begin
                norm_min  = MIN_MAX;
                norm_tens = SEC_TENS_MAX;
                norm_ones = BCD_MAX;
                clamped   = 1'b1;
            end else begin
                norm_min  = raw_min + 4'd1;
                norm_tens = raw_tens - WRAP_TENS;
            end
        end
`else
        invalid = (raw_tens > SEC_TENS_MAX);
`endif
    end

endmodule

// File: rtl/timer_digit_entry.sv
// Keypad digit-entry and counter-load controller for the microwave timer.
// Build option TIMER_ENTRY_NORM_EN enables seconds carry and 9:59 clamping in the normaliser.
module timer_digit_entry
    import timer_pkg::*;
(
    input  logic             clk,
    input  logic             clr,
    input  logic [BCD_W-1:0] digit,
    input  logic             digit_valid,
    input  logic             start,
    input  logic             cancel,
    input  logic             expired,
    output logic [BCD_W-1:0] min_data,
    output logic [BCD_W-1:0] sec_tens_data,
    output logic [BCD_W-1:0] sec_ones_data,
    output logic             loadn,
    output logic             run,
    output logic [1:0]       digit_count,
    output logic             err
);

    state_t state_q, state_d;
    logic [BCD_W-1:0] min_q, min_d;
    logic [BCD_W-1:0] tens_q, tens_d;
    logic [BCD_W-1:0] ones_q, ones_d;
    logic [1:0]       count_q, count_d;
    logic             loadn_q, loadn_d;
    logic             run_q, run_d;
    logic             err_q, err_d;

    logic [BCD_W-1:0] norm_min, norm_tens, norm_ones;
    logic             norm_invalid;
    logic             unused_norm_clamped;
    logic             bad_digit;

    timer_normalize u_normalize (
        .raw_min   (min_q),
        .raw_tens  (tens_q),
        .raw_ones  (ones_q),
        .norm_min  (norm_min),
        .norm_tens (norm_tens),
        .norm_ones (norm_ones),
        .clamped   (unused_norm_clamped),
        .invalid   (norm_invalid)
    );

    // A digit is only judged when no higher-priority strobe shares its cycle.
    assign bad_digit = digit_valid && !start && !cancel && (digit > BCD_MAX);

    always_comb begin
        state_d = state_q;
        min_d   = min_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        count_d = count_q;
        loadn_d = 1'b1;
        run_d   = run_q;
        err_d   = bad_digit;

        if (cancel) begin
            state_d = IDLE;
            min_d   = '0;
            tens_d  = '0;
            ones_d  = '0;
            count_d = 2'd0;
            run_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        err_d = 1'b1;
                    end else if (digit_valid && !bad_digit) begin
                        state_d = ENTRY;
                        ones_d  = digit;
                        count_d = 2'd1;
                    end
                end
                ENTRY: begin
                    // Normalised digits are captured on the start edge so the bus is steady from NORM onward.
                    if (start) begin
                        if (norm_invalid) begin
                            err_d = 1'b1;
                        end else begin
                            state_d = NORM;
                            min_d   = norm_min;
                            tens_d  = norm_tens;
                            ones_d  = norm_ones;
                        end
                    end else if (digit_valid && !bad_digit) begin
                        if (count_q == 2'd3) begin
                            err_d = 1'b1;
                        end else begin
                            min_d   = tens_q;
                            tens_d  = ones_q;
                            ones_d  = digit;
                            count_d = count_q + 2'd1;
                        end
                    end
                end
                NORM: begin
                    state_d = LOAD;
                    loadn_d = 1'b0;
                end
                LOAD: begin
                    state_d = RUN;
                    run_d   = 1'b1;
                end
                RUN: begin
                    if (expired) begin
                        state_d = IDLE;
                        min_d   = '0;
                        tens_d  = '0;
                        ones_d  = '0;
                        count_d = 2'd0;
                        run_d   = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    min_d   = '0;
                    tens_d  = '0;
                    ones_d  = '0;
                    count_d = 2'd0;
                    run_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= IDLE;
            min_q   <= '0;
            tens_q  <= '0;
            ones_q  <= '0;
            count_q <= 2'd0;
            loadn_q <= 1'b1;
            run_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            min_q   <= min_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            count_q <= count_d;
            loadn_q <= loadn_d;
            run_q   <= run_d;
            err_q   <= err_d;
        end
    end

    assign min_data      = min_q;
    assign sec_tens_data = tens_q;
    assign sec_ones_data = ones_q;
    assign loadn         = loadn_q;
    assign run           = run_q;
    assign digit_count   = count_q;
    assign err           = err_q;

endmodule

// File: tb/tb_timer_digit_entry.sv
// Self-checking bench for timer_digit_entry: directed scenarios with literal expectations
// plus randomized strobes compared every cycle against a time-in-seconds reference model.
module tb_timer_digit_entry;

`ifdef TIMER_ENTRY_NORM_EN
    localparam bit NORM_EN = 1'b1;
`else
    localparam bit NORM_EN = 1'b0;
`endif

    localparam int M_IDLE  = 0;
    localparam int M_ENTRY = 1;
    localparam int M_NORM  = 2;
    localparam int M_LOAD  = 3;
    localparam int M_RUN   = 4;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic [3:0] digit = 4'd0;
    logic       digit_valid = 1'b0;
    logic       start = 1'b0;
    logic       cancel = 1'b0;
    logic       expired = 1'b0;
    logic [3:0] min_data, sec_tens_data, sec_ones_data;
    logic       loadn, run, err;
    logic [1:0] digit_count;

    int checks = 0;
    int failures = 0;

    timer_digit_entry dut (
        .clk           (clk),
        .clr           (clr),
        .digit         (digit),
        .digit_valid   (digit_valid),
        .start         (start),
        .cancel        (cancel),
        .expired       (expired),
        .min_data      (min_data),
        .sec_tens_data (sec_tens_data),
        .sec_ones_data (sec_ones_data),
        .loadn         (loadn),
        .run           (run),
        .digit_count   (digit_count),
        .err           (err)
    );

    always #5 clk = ~clk;

    // Reference model: entered digits as a queue, committed time as M:SS digits.
    int m_mode = M_IDLE;
    int m_q[$];
    int m_min = 0, m_tens = 0, m_ones = 0;
    bit m_loadn = 1'b1, m_run = 1'b0, m_err = 1'b0;

    function automatic logic [16:0] pack(int mn, int tn, int on, logic ld, logic rn, int cnt, logic er);
        return {4'(mn), 4'(tn), 4'(on), ld, rn, 2'(cnt), er};
    endfunction

    function automatic logic [16:0] dut_vec();
        return {min_data, sec_tens_data, sec_ones_data, loadn, run, digit_count, err};
    endfunction

    task automatic model_clear();
        m_mode = M_IDLE;
        m_q.delete();
        m_min = 0; m_tens = 0; m_ones = 0;
        m_run = 1'b0;
    endtask

    task automatic model_step();
        bit e;
        int n, secs, mn, tn, on;
        if (clr) begin
            model_clear();
            m_loadn = 1'b1;
            m_err = 1'b0;
            return;
        end
        n = m_q.size();
        e = digit_valid && !start && !cancel && (digit > 9);
        m_loadn = 1'b1;
        if (cancel) begin
            model_clear();
        end else begin
            case (m_mode)
                M_IDLE: begin
                    if (start) e = 1'b1;
                    else if (digit_valid && digit <= 9) begin
                        m_q.push_back(int'(digit));
                        m_mode = M_ENTRY;
                    end
                end
                M_ENTRY: begin
                    if (start) begin
                        on = m_q[n-1];
                        tn = (n >= 2) ? m_q[n-2] : 0;
                        mn = (n == 3) ? m_q[0] : 0;
                        if (!NORM_EN && tn > 5) e = 1'b1;
                        else begin
                            secs = mn * 60 + tn * 10 + on;
                            if (secs > 599) secs = 599;
                            m_min  = secs / 60;
                            m_tens = (secs % 60) / 10;
                            m_ones = secs % 10;
                            m_mode = M_NORM;
                        end
                    end else if (digit_valid && digit <= 9) begin
                        if (n == 3) e = 1'b1;
                        else m_q.push_back(int'(digit));
                    end
                end
                M_NORM: begin
                    m_mode = M_LOAD;
                    m_loadn = 1'b0;
                end
                M_LOAD: begin
                    m_mode = M_RUN;
                    m_run = 1'b1;
                end
                default: begin
                    if (expired) model_clear();
                end
            endcase
        end
        m_err = e;
    endtask

    function automatic logic [16:0] model_vec();
        int n;
        n = m_q.size();
        if (m_mode == M_IDLE) return pack(0, 0, 0, m_loadn, m_run, 0, m_err);
        if (m_mode == M_ENTRY)
            return pack((n == 3) ? m_q[0] : 0, (n >= 2) ? m_q[n-2] : 0, m_q[n-1],
                        m_loadn, m_run, n, m_err);
        return pack(m_min, m_tens, m_ones, m_loadn, m_run, n, m_err);
    endfunction

    task automatic checkOutput(input string name, input logic [16:0] act, input logic [16:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h (min,tens,ones,loadn,run,count,err)",
                     name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic dv, input logic [3:0] d, input logic st,
                                 input logic cn, input logic ex);
        @(negedge clk);
        digit_valid = dv; digit = d; start = st; cancel = cn; expired = ex;
        @(posedge clk);
        #1;
        digit_valid = 1'b0; start = 1'b0; cancel = 1'b0; expired = 1'b0;
    endtask

    task automatic key(input int d);
        applyStimulus(1'b1, 4'(d), 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle();
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Every-cycle comparison of the DUT against the model.
    initial begin
        forever begin
            @(posedge clk);
            model_step();
            #1;
            checkOutput("cycle", dut_vec(), model_vec());
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_state", dut_vec(), pack(0, 0, 0, 1, 0, 0, 0));
        clr = 1'b0;

        key(1); key(3); key(0);
        checkOutput("entry_130", dut_vec(), pack(1, 3, 0, 1, 0, 3, 0));
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        checkOutput("norm_130", dut_vec(), pack(1, 3, 0, 1, 0, 3, 0));
        idle();
        checkOutput("load_130", dut_vec(), pack(1, 3, 0, 0, 0, 3, 0));
        idle();
        checkOutput("run_130", dut_vec(), pack(1, 3, 0, 1, 1, 3, 0));
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("expired_idle", dut_vec(), pack(0, 0, 0, 1, 0, 0, 0));

        key(9); key(9);
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        if (NORM_EN) begin
            checkOutput("norm_99", dut_vec(), pack(1, 3, 9, 1, 0, 2, 0));
            idle();
            checkOutput("load_99", dut_vec(), pack(1, 3, 9, 0, 0, 2, 0));
        end else begin
            checkOutput("reject_99", dut_vec(), pack(0, 9, 9, 1, 0, 2, 1));
            idle();
            checkOutput("reject_99_noload", dut_vec(), pack(0, 9, 9, 1, 0, 2, 0));
        end
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        checkOutput("cancel_99", dut_vec(), pack(0, 0, 0, 1, 0, 0, 0));

        key(9); key(9); key(9);
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        if (NORM_EN) begin
            idle();
            checkOutput("load_959", dut_vec(), pack(9, 5, 9, 0, 0, 3, 0));
        end else begin
            checkOutput("reject_999", dut_vec(), pack(9, 9, 9, 1, 0, 3, 1));
        end
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);

        key(1); key(2); key(3); key(4);
        checkOutput("fourth_digit", dut_vec(), pack(1, 2, 3, 1, 0, 3, 1));
        key(10);
        checkOutput("bad_digit", dut_vec(), pack(1, 2, 3, 1, 0, 3, 1));
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        checkOutput("cancel_entry", dut_vec(), pack(0, 0, 0, 1, 0, 0, 0));

        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        checkOutput("start_idle", dut_vec(), pack(0, 0, 0, 1, 0, 0, 1));
        idle();
        checkOutput("start_idle_noload", dut_vec(), pack(0, 0, 0, 1, 0, 0, 0));
        key(5);
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
        checkOutput("cancel_with_start", dut_vec(), pack(0, 0, 0, 1, 0, 0, 0));
        idle();
        checkOutput("cancel_with_start_noload", dut_vec(), pack(0, 0, 0, 1, 0, 0, 0));

        key(2);
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        idle();
        checkOutput("load_002", dut_vec(), pack(0, 0, 2, 0, 0, 1, 0));
        @(negedge clk);
        clr = 1'b1;
        #1;
        checkOutput("clr_in_load", dut_vec(), pack(0, 0, 0, 1, 0, 0, 0));
        @(posedge clk);
        @(negedge clk);
        clr = 1'b0;

        // Randomized strobes; expired kept rare so RUN is held long enough to see stray inputs.
        for (int i = 0; i < 4000; i++) begin
            logic dv, st, cn, ex;
            logic [3:0] d;
            dv = ($urandom_range(0, 99) < 45);
            st = ($urandom_range(0, 99) < 10);
            cn = ($urandom_range(0, 99) < 3);
            ex = ($urandom_range(0, 99) < 8);
            d  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            applyStimulus(dv, d, st, cn, ex);
        end

        idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/timer_digit_entry.md
# timer_digit_entry

Keypad digit-entry and load controller for the microwave timer, sitting directly upstream of the seconds-ones, seconds-tens (mod-6) and minutes BCD down-counters. It shifts up to three BCD digits in microwave-style (right-to-left), normalises the entered time into valid M:SS form, and drives the counters' shared parallel-load bus and active-low load strobe. It then holds a run flag until the time expires or entry is cancelled.

## Interface
- Parameters: none.
- `clk`  in  1  single system clock, all state on rising edge.
- `clr`  in  1  reset, asynchronous, active-high.
- `digit`  in  4  BCD keypad digit.
- `digit_valid`  in  1  one-cycle strobe qualifying `digit`.
- `start`  in  1  one-cycle strobe: commit entry and load counters.
- `cancel`  in  1  one-cycle strobe: abort entry or run.
- `expired`  in  1  level from the counter chain: all digits zero while running.
- `min_data`  out  4  minutes load value.
- `sec_tens_data`  out  4  seconds-tens load value, always 0..5 when loaded.
- `sec_ones_data`  out  4  seconds-ones load value.
- `loadn`  out  1  active-low synchronous load strobe to all three counters.
- `run`  out  1  high while the timer is counting.
- `digit_count`  out  2  digits currently held, 0..3.
- `err`  out  1  one-cycle pulse on a rejected input.

## Operation
- FSM states: IDLE, ENTRY, NORM, LOAD, RUN.
- IDLE: registers zero, `digit_count`=0. A valid digit moves to ENTRY with that digit in ones.
- ENTRY: each accepted digit shifts left: min←tens, tens←ones, ones←digit; `digit_count`++.
  - 4th digit: ignored, `err` pulse.
  - Digit > 9 in any state: ignored, `err` pulse.
- `start` in ENTRY → NORM. `start` in IDLE: `err` pulse, no load. `start` in NORM/LOAD/RUN: ignored, no error.
- NORM (one cycle): convert raw M:SS with SS = 10·tens+ones (0..99):
  - If SS ≥ 60: SS −= 60, M += 1.
  - If M > 9 after carry: clamp to 9:59.
- LOAD (one cycle): `loadn`=0; data outputs carry normalised values.
- RUN: `run`=1, data outputs held. Leaves to IDLE on `expired`=1 or `cancel`. A digit strobe in RUN is ignored without error.
- `cancel` in any state → IDLE, registers cleared, `run`=0.
- Same-cycle priority: `cancel` > `start` > `digit_valid`. A digit arriving with `start` is dropped without `err`.

## Timing
- Reset values: all data outputs 0, `loadn`=1, `run`=0, `digit_count`=0, `err`=0, state IDLE.
- Digit sampled at edge N; registers and `digit_count` are visible after edge N.
- `start` sampled at edge N puts the FSM in NORM. Edge N+1 → LOAD, with `loadn`=0 during the N+1..N+2 cycle. Edge N+2 → RUN.
- `loadn` is low for exactly one cycle. Data outputs are stable from entering NORM through all of RUN.
- Downstream counters load only while their `en`=0; `run` rises after the load cycle, so `en` gating keyed on `run` is safe.
- `err` is registered, one cycle wide, asserted the cycle after the offending strobe.
- `clr` mid-operation, including during LOAD: immediate return to reset values, `loadn` forced to 1.
- `expired` is ignored outside RUN.

## Configuration
- `TIMER_ENTRY_NORM_EN` defined: NORM performs the SS ≥ 60 carry and the 9:59 clamp as above.
- Not defined:
  - `start` with entered tens > 5: `err` pulse, FSM stays in ENTRY with digits kept.
  - Valid entries go through NORM unchanged, so latency is identical in both builds.

## Structure
- Shared `timer_pkg` holds:
  - state enum type;
  - constants `SEC_TENS_MAX`=5, `MIN_MAX`=9, `SEC_WRAP`=60;
  - `BCD_W`=4.
- Sub-module `timer_normalize`: purely combinational BCD M:SS normaliser (raw min/tens/ones in, normalised digits plus clamp flag out), instantiated once in NORM data path. All macro-dependent arithmetic lives there.

## Test plan
- Digits 1,3,0 then `start` → `loadn` low exactly 2 cycles after start; data 1/3/0; `run`=1 next cycle.
- Digits 9,9 then `start`, macro defined → load 1/3/9. Macro undefined → `err` pulse, no `loadn`, `digit_count`=2.
- Digits 9,9,9 then `start`, macro defined → load 9/5/9 (clamped).
- Digits 1,2,3,4 → 4th produces `err`, `digit_count` stays 3, data 1/2/3. `digit`=4'hA → `err`, no shift.
- `start` in IDLE → `err`, no `loadn`. `cancel` asserted with `start` in ENTRY → IDLE, no load.
- In RUN, raise `expired` → IDLE, `run`=0. Assert `clr` during LOAD → `loadn`=1 and all outputs 0 immediately.
